branch_fwd_ctrl: RTL and testbench
==================================

Name: branch_fwd_ctrl

Overview:
Forwarding and hazard controller for the ID-stage branch comparator. It tracks the destination register of every instruction in EX, MEM and WB in an internal shadow pipeline. From that state it generates the 2-bit operand-select codes consumed by the comparator's operand muxes, and it raises a stall whenever a branch operand comes from a load whose data is not yet available. It sits beside the hazard unit in the ID stage and drives both comparator operand muxes, A (rs) and B (rt).

Parameters:
REG_W, 5, register-specifier width
PERF_W, 16, width of stall/forward event counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
hold  in  1  global pipeline freeze (e.g. memory wait); tracker does not advance
id_valid  in  1  ID holds a real instruction
id_is_branch  in  1  ID instruction uses the comparator (beq/bne/etc.)
id_rs  in  REG_W  ID source register A
id_rt  in  REG_W  ID source register B
id_use_rt  in  1  branch compares rt (0 for bgez/bltz-class)
id_wr_en  in  1  ID instruction writes a register
id_wr_reg  in  REG_W  ID destination register
id_is_load  in  1  ID instruction is a load
ex_flush  in  1  squash the instruction entering EX this cycle
cmpsrc_a  out  2  select for operand A: 00 regfile, 01 id_ex (EX ALU result), 10 ex_mem, 11 mem_wb
cmpsrc_b  out  2  select for operand B, same encoding
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
stall_cnt  out  PERF_W  saturating count of cycles with stall=1
fwd_cnt  out  PERF_W  saturating count of branch cycles with any nonzero select

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- State: three slots EX, MEM, WB. Each slot holds {vld, wr_en, dst, is_load}. On rst, all slots are cleared to 0 and both counters to 0.
- Advance: on each rising edge with hold=0:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields, gated by id_valid & ~stall & ~ex_flush; otherwise EX gets a bubble (vld=0).
- hold=1: all slots and counters keep their values. hold dominates stall and ex_flush.
- Match rule: slot S matches register r iff S.vld & S.wr_en & (S.dst==r) & (r!=0). Register $0 never forwards or stalls.
- Select priority, evaluated per operand and youngest first:
  - EX match & ~is_load -> 01.
  - Else MEM match & ~is_load -> 10.
  - Else WB match -> 11. This covers a load or ALU result in WB. The comparator never relies on register-file write-through.
  - Else 00.
- Load hazard: a branch operand whose youngest match is a load in EX or in MEM -> stall=1, and the select for that operand is forced to 00. The select value is don't-care to the consumer while stalling.
- Select qualification: selects are nonzero only when id_valid & id_is_branch. Operand B is considered only when id_use_rt=1; otherwise cmpsrc_b=00.
- Timing: cmpsrc_a, cmpsrc_b and stall are combinational from slot state and ID inputs, with zero latency. The counters are registered.
- Stall latency:
  - Branch directly after a load: 2 stall cycles, then 11.
  - Branch one instruction after a load: 1 stall cycle, then 11.
  - ALU producer: no stall.
- Stall with hold: if stall=1 and hold=1, no bubble is inserted and state is frozen; stall stays asserted.
- Counters:
  - stall_cnt increments on edges where stall & ~hold.
  - fwd_cnt increments on edges where ~hold & ~stall & (cmpsrc_a!=0 | cmpsrc_b!=0).
  - Both saturate at all-ones and do not wrap.
- Reset mid-operation: asynchronous clear of all state. Outputs go to 00/00/0 in the same cycle the reset asserts.
- Simultaneous events: rs==rt both matching -> both selects identical. A producer in both EX and MEM for the same register -> EX wins.

Decomposition:
- Shared package: the cmpsrc encoding constants (SRC_REG=2'b00, SRC_IDEX=2'b01, SRC_EXMEM=2'b10, SRC_MEMWB=2'b11) and the slot record typedef {vld, wr_en, dst, is_load}. The existing comparator operand mux consumes the same constants.
- One sub-module, fwd_sel: purely combinational. It takes one register specifier plus the three slots and returns {sel[1:0], load_hazard}. It is instantiated twice, once for A and once for B.

Test Plan:
- addu $3 into EX, then beq $3,$4 in ID -> cmpsrc_a=01, cmpsrc_b=00, stall=0; next edge fwd_cnt=1.
- addu $5, nop, then bne $6,$5 -> cmpsrc_b=10 while addu is in MEM; one more nop between them -> cmpsrc_b=11.
- lw $7 immediately followed by beq $7,$0 -> stall=1 for exactly 2 cycles (stall_cnt=2), then cmpsrc_a=11, stall=0.
- addu $0 into EX, then beq $0,$0 -> selects 00/00, no stall. Separately: addu $2 in EX and lw $2 in MEM, then beq $2 -> 01, no stall.
- Load-hazard stall with hold=1 for 3 cycles -> stall stays 1, slots and stall_cnt frozen. Release hold -> stall sequence completes normally.
- rst pulsed asynchronously mid-stall -> stall, cmpsrc_a and cmpsrc_b go to 0 before the next edge; both counters read 0.

Source files
------------

// File: rtl/branch_fwd_ctrl_pkg.sv
// Shared definitions for the branch-comparator forwarding controller.
// Holds the operand-select encoding (also used by the comparator operand
// muxes) and the record kept for each shadow-pipeline slot.
package branch_fwd_ctrl_pkg;

  localparam int SLOT_REG_W = 5;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IDEX  = 2'b01;
  localparam logic [1:0] SRC_EXMEM = 2'b10;
  localparam logic [1:0] SRC_MEMWB = 2'b11;

  typedef struct packed {
    logic                  vld;
    logic                  wr_en;
    logic [SLOT_REG_W-1:0] dst;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/branch_fwd_ctrl_fwd_sel.sv
// Per-operand forwarding select for the ID-stage branch comparator.
// Ports:
//   i_reg          source register specifier of the operand
//   i_ex/i_mem/i_wb shadow slots for the instructions in EX, MEM, WB
//   o_sel          operand-mux select (SRC_* encoding)
//   o_load_hazard  youngest producer is a load whose data is not ready yet
module fwd_sel
  import branch_fwd_ctrl_pkg::*;
(
  input  logic [SLOT_REG_W-1:0] i_reg,
  input  slot_t                 i_ex,
  input  slot_t                 i_mem,
  input  slot_t                 i_wb,
  output logic [1:0]            o_sel,
  output logic                  o_load_hazard
);

  logic w_nonzero;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  // $0 is hardwired to zero, so it never matches a producer.
  assign w_nonzero = (i_reg != '0);
  assign w_hit_ex  = w_nonzero & i_ex.vld  & i_ex.wr_en  & (i_ex.dst  == i_reg);
  assign w_hit_mem = w_nonzero & i_mem.vld & i_mem.wr_en & (i_mem.dst == i_reg);
  assign w_hit_wb  = w_nonzero & i_wb.vld  & i_wb.wr_en  & (i_wb.dst  == i_reg);

  // Youngest producer wins. A load still in EX or MEM has no data to
  // forward, so the operand is held at the register-file path and flagged.
  always_comb begin
    o_sel         = SRC_REG;
    o_load_hazard = 1'b0;
    if (w_hit_ex) begin
      if (i_ex.is_load) o_load_hazard = 1'b1;
      else              o_sel         = SRC_IDEX;
    end else if (w_hit_mem) begin
      if (i_mem.is_load) o_load_hazard = 1'b1;
      else               o_sel         = SRC_EXMEM;
    end else if (w_hit_wb) begin
      o_sel = SRC_MEMWB;
    end
  end

endmodule

// File: rtl/branch_fwd_ctrl.sv
// Forwarding and load-hazard controller for the ID-stage branch comparator.
// Tracks EX/MEM/WB destinations in a shadow pipeline and produces the
// comparator operand selects plus a stall for unresolved load producers.
// Ports:
//   clk, rst (async, active-high), hold (freeze tracker and counters)
//   id_*      decoded fields of the instruction in ID
//   ex_flush  squash the instruction entering EX
//   cmpsrc_a/b operand-mux selects (SRC_* encoding), stall
//   stall_cnt/fwd_cnt saturating event counters
module branch_fwd_ctrl
  import branch_fwd_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_W-1:0]  id_wr_reg,
  input  logic              id_is_load,
  input  logic              ex_flush,
  output logic [1:0]        cmpsrc_a,
  output logic [1:0]        cmpsrc_b,
  output logic              stall,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] fwd_cnt
);

  slot_t             r_ex;
  slot_t             r_mem;
  slot_t             r_wb;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_fwd_cnt;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_haz_a;
  logic       w_haz_b;
  logic       w_branch;
  logic       w_use_b;
  logic       w_stall;
  logic       w_fwd;
  logic       w_issue;
  slot_t      w_ex_next;

  fwd_sel u_sel_a (
    .i_reg         (id_rs),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_wb          (r_wb),
    .o_sel         (w_sel_a),
    .o_load_hazard (w_haz_a)
  );

  fwd_sel u_sel_b (
    .i_reg         (id_rt),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_wb          (r_wb),
    .o_sel         (w_sel_b),
    .o_load_hazard (w_haz_b)
  );

  // Selects only matter for a real branch; B is ignored by rs-only branches.
  assign w_branch = id_valid & id_is_branch;
  assign w_use_b  = w_branch & id_use_rt;
  assign cmpsrc_a = w_branch ? w_sel_a : SRC_REG;
  assign cmpsrc_b = w_use_b  ? w_sel_b : SRC_REG;
  assign w_stall  = (w_branch & w_haz_a) | (w_use_b & w_haz_b);
  assign stall    = w_stall;
  assign w_fwd    = ~w_stall & ((cmpsrc_a != SRC_REG) | (cmpsrc_b != SRC_REG));

  // A stalled or flushed instruction enters EX as a bubble.
  assign w_issue   = id_valid & ~w_stall & ~ex_flush;
  assign w_ex_next = w_issue ? '{vld: 1'b1, wr_en: id_wr_en, dst: id_wr_reg,
                                 is_load: id_is_load}
                             : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_fwd && (r_fwd_cnt != '1))     r_fwd_cnt   <= r_fwd_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
module tb_branch_fwd_ctrl;

  localparam int REG_W  = 5;
  localparam int PERF_W = 4;   // narrow counters so saturation is reachable

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hold = 1'b0;
  logic              id_valid = 1'b0;
  logic              id_is_branch = 1'b0;
  logic [REG_W-1:0]  id_rs = '0;
  logic [REG_W-1:0]  id_rt = '0;
  logic              id_use_rt = 1'b0;
  logic              id_wr_en = 1'b0;
  logic [REG_W-1:0]  id_wr_reg = '0;
  logic              id_is_load = 1'b0;
  logic              ex_flush = 1'b0;
  logic [1:0]        cmpsrc_a;
  logic [1:0]        cmpsrc_b;
  logic              stall;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] fwd_cnt;

  int errors = 0;
  int checks = 0;

  branch_fwd_ctrl #(.REG_W(REG_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
    .id_is_branch(id_is_branch), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .cmpsrc_a(cmpsrc_a),
    .cmpsrc_b(cmpsrc_b), .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: instruction history indexed by age (1=EX, 2=MEM, 3=WB).
  logic       m_vld [1:3];
  logic       m_wr  [1:3];
  logic [4:0] m_dst [1:3];
  logic       m_ld  [1:3];
  int         m_stall_cnt;
  int         m_fwd_cnt;
  localparam int CNT_MAX = (1 << PERF_W) - 1;

  function automatic void model_reset();
    for (int a = 1; a <= 3; a++) begin
      m_vld[a] = 0; m_wr[a] = 0; m_dst[a] = 0; m_ld[a] = 0;
    end
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
  endfunction

  // {select, hazard}: select code equals the producer's age; a load that
  // has not reached WB yields a hazard instead.
  function automatic logic [2:0] m_opnd(input logic [4:0] r);
    for (int a = 1; a <= 3; a++) begin
      if (m_vld[a] && m_wr[a] && m_dst[a] == r && r != 0) begin
        if (m_ld[a] && a < 3) return 3'b001;
        return {a[1:0], 1'b0};
      end
    end
    return 3'b000;
  endfunction

  function automatic void model_eval(output logic [1:0] ea, output logic [1:0] eb,
                                     output logic es);
    logic [2:0] ra, rb;
    logic br;
    ra = m_opnd(id_rs);
    rb = m_opnd(id_rt);
    br = id_valid && id_is_branch;
    ea = br ? ra[2:1] : 2'b00;
    eb = (br && id_use_rt) ? rb[2:1] : 2'b00;
    es = (br && ra[0]) || (br && id_use_rt && rb[0]);
  endfunction

  function automatic void model_advance();
    logic [1:0] ea, eb;
    logic es;
    model_eval(ea, eb, es);
    if (hold) return;
    if (es) m_stall_cnt = (m_stall_cnt >= CNT_MAX) ? CNT_MAX : m_stall_cnt + 1;
    if (!es && (ea != 0 || eb != 0))
      m_fwd_cnt = (m_fwd_cnt >= CNT_MAX) ? CNT_MAX : m_fwd_cnt + 1;
    for (int a = 3; a >= 2; a--) begin
      m_vld[a] = m_vld[a-1]; m_wr[a] = m_wr[a-1];
      m_dst[a] = m_dst[a-1]; m_ld[a] = m_ld[a-1];
    end
    if (id_valid && !es && !ex_flush) begin
      m_vld[1] = 1; m_wr[1] = id_wr_en; m_dst[1] = id_wr_reg; m_ld[1] = id_is_load;
    end else begin
      m_vld[1] = 0; m_wr[1] = 0; m_dst[1] = 0; m_ld[1] = 0;
    end
  endfunction

  // Advance one clock: the model sees the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_id(input logic v, input logic br, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic we,
                        input logic [4:0] wr, input logic ld);
    id_valid = v; id_is_branch = br; id_rs = rs; id_rt = rt; id_use_rt = urt;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld;
  endtask

  task automatic alu(input logic [4:0] d);   set_id(1, 0, 0, 0, 0, 1, d, 0); endtask
  task automatic lw(input logic [4:0] d);    set_id(1, 0, 0, 0, 0, 1, d, 1); endtask
  task automatic nop();                      set_id(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic br2(input logic [4:0] s, input logic [4:0] t); set_id(1, 1, s, t, 1, 0, 0, 0); endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    checks++; if (cmpsrc_a !== 2'b00) begin errors++; $display("FAIL reset_a got=%b exp=00", cmpsrc_a); end
    checks++; if (cmpsrc_b !== 2'b00) begin errors++; $display("FAIL reset_b got=%b exp=00", cmpsrc_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (fwd_cnt !== '0) begin errors++; $display("FAIL reset_fwd_cnt got=%0d exp=0", fwd_cnt); end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_alu_ex();
    drain();
    alu(3); tick();
    br2(3, 4); #1;
    checks++; if (cmpsrc_a !== 2'b01 || cmpsrc_b !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL alu_ex got=%b/%b/%b exp=01/00/0", cmpsrc_a, cmpsrc_b, stall); end
    tick();
    checks++; if (fwd_cnt !== PERF_W'(m_fwd_cnt) || fwd_cnt !== PERF_W'(1)) begin
      errors++; $display("FAIL alu_ex_fwd_cnt got=%0d exp=1", fwd_cnt); end
  endtask

  task automatic test_mem_wb();
    drain();
    alu(5); tick(); nop(); tick();
    br2(6, 5); #1;
    checks++; if (cmpsrc_b !== 2'b10 || cmpsrc_a !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL mem_fwd got=%b/%b/%b exp=00/10/0", cmpsrc_a, cmpsrc_b, stall); end
    drain();
    alu(5); tick(); nop(); tick(); tick();
    br2(6, 5); #1;
    checks++; if (cmpsrc_b !== 2'b11 || stall !== 1'b0) begin
      errors++; $display("FAIL wb_fwd got=%b/%b exp=11/0", cmpsrc_b, stall); end
  endtask

  task automatic test_load_stall();
    int base;
    drain();
    base = m_stall_cnt;
    lw(7); tick();
    br2(7, 0); #1;
    checks++; if (stall !== 1'b1 || cmpsrc_a !== 2'b00) begin
      errors++; $display("FAIL load_stall1 got=%b/%b exp=1/00", stall, cmpsrc_a); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall2 got=%b exp=1", stall); end
    tick();
    checks++; if (stall !== 1'b0 || cmpsrc_a !== 2'b11 || cmpsrc_b !== 2'b00) begin
      errors++; $display("FAIL load_release got=%b/%b/%b exp=11/00/0", cmpsrc_a, cmpsrc_b, stall); end
    checks++; if (stall_cnt !== PERF_W'(base + 2)) begin
      errors++; $display("FAIL load_stall_cnt got=%0d exp=%0d", stall_cnt, base + 2); end
  endtask

  task automatic test_zero_and_priority();
    drain();
    alu(0); tick();
    br2(0, 0); #1;
    checks++; if (cmpsrc_a !== 2'b00 || cmpsrc_b !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL reg0 got=%b/%b/%b exp=00/00/0", cmpsrc_a, cmpsrc_b, stall); end
    drain();
    lw(2); tick(); alu(2); tick();
    br2(2, 2); #1;
    checks++; if (cmpsrc_a !== 2'b01 || cmpsrc_b !== 2'b01 || stall !== 1'b0) begin
      errors++; $display("FAIL ex_over_mem got=%b/%b/%b exp=01/01/0", cmpsrc_a, cmpsrc_b, stall); end
    set_id(1, 1, 1, 2, 0, 0, 0, 0); #1;
    checks++; if (cmpsrc_b !== 2'b00) begin
      errors++; $display("FAIL use_rt_off got=%b exp=00", cmpsrc_b); end
  endtask

  task automatic test_flush();
    drain();
    alu(9); ex_flush = 1; tick(); ex_flush = 0;
    br2(9, 1); #1;
    checks++; if (cmpsrc_a !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL flush got=%b/%b exp=00/0", cmpsrc_a, stall); end
  endtask

  task automatic test_hold();
    logic [PERF_W-1:0] saved;
    drain();
    lw(7); tick();
    br2(7, 3); #1;
    saved = stall_cnt;
    hold = 1;
    repeat (3) begin
      tick();
      checks++; if (stall !== 1'b1 || stall_cnt !== saved) begin
        errors++; $display("FAIL hold_freeze got=%b/%0d exp=1/%0d", stall, stall_cnt, saved); end
    end
    hold = 0;
    tick();
    checks++; if (stall !== 1'b1 || stall_cnt !== PERF_W'(saved + 1)) begin
      errors++; $display("FAIL hold_release1 got=%b/%0d exp=1/%0d", stall, stall_cnt, saved + 1); end
    tick();
    checks++; if (stall !== 1'b0 || cmpsrc_a !== 2'b11 || stall_cnt !== PERF_W'(saved + 2)) begin
      errors++; $display("FAIL hold_release2 got=%b/%b/%0d exp=0/11/%0d", stall, cmpsrc_a, stall_cnt, saved + 2); end
  endtask

  task automatic test_saturation();
    drain();
    repeat (9) begin
      lw(7); tick();
      br2(7, 0); repeat (3) tick();
    end
    checks++; if (stall_cnt !== '1) begin
      errors++; $display("FAIL stall_cnt_sat got=%0d exp=%0d", stall_cnt, CNT_MAX); end
    checks++; if (fwd_cnt !== PERF_W'(m_fwd_cnt)) begin
      errors++; $display("FAIL fwd_cnt_sat got=%0d exp=%0d", fwd_cnt, m_fwd_cnt); end
  endtask

  task automatic test_reset_mid();
    drain();
    lw(4); tick();
    br2(4, 0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
    rst = 1; #1;
    checks++; if (stall !== 1'b0 || cmpsrc_a !== 2'b00 || cmpsrc_b !== 2'b00) begin
      errors++; $display("FAIL mid_reset_out got=%b/%b/%b exp=00/00/0", cmpsrc_a, cmpsrc_b, stall); end
    checks++; if (stall_cnt !== '0 || fwd_cnt !== '0) begin
      errors++; $display("FAIL mid_reset_cnt got=%0d/%0d exp=0/0", stall_cnt, fwd_cnt); end
    #2 rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    logic es;
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      hold     = ($urandom_range(0, 7) == 0);
      ex_flush = ($urandom_range(0, 7) == 0);
      #1;
      model_eval(ea, eb, es);
      checks++; if (cmpsrc_a !== ea) begin errors++; $display("FAIL rnd_a cyc=%0d got=%b exp=%b", i, cmpsrc_a, ea); end
      checks++; if (cmpsrc_b !== eb) begin errors++; $display("FAIL rnd_b cyc=%0d got=%b exp=%b", i, cmpsrc_b, eb); end
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, es); end
      checks++; if (stall_cnt !== PERF_W'(m_stall_cnt)) begin
        errors++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall_cnt); end
      checks++; if (fwd_cnt !== PERF_W'(m_fwd_cnt)) begin
        errors++; $display("FAIL rnd_fwd_cnt cyc=%0d got=%0d exp=%0d", i, fwd_cnt, m_fwd_cnt); end
      tick();
    end
    hold = 0; ex_flush = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_ex();
    test_mem_wb();
    test_load_stall();
    test_zero_and_priority();
    test_flush();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
